// File: rtl/contadores_param_if.sv
// -----------------------------------------------------------------------------
// contadores_param_if
// Readout port of the word counter block. The host raises req with a channel
// number on idx. One cycle later the counter block answers on data/valid, or
// it pulses rd_err if it refuses the request.
//   req    host -> counters  readout request, sampled every cycle
//   idx    host -> counters  channel selected for readout
//   data   counters -> host  registered count of the selected channel
//   valid  counters -> host  one-cycle qualifier for data
//   rd_err counters -> host  one-cycle pulse for a rejected request
// -----------------------------------------------------------------------------
interface contadores_param_if #(
  parameter int IDX_BITS = 2,
  parameter int CNT_BITS = 5
);
  logic                req;
  logic [IDX_BITS-1:0] idx;
  logic [CNT_BITS-1:0] data;
  logic                valid;
  logic                rd_err;

  modport master (
    output req,
    output idx,
    input  data,
    input  valid,
    input  rd_err
  );

  modport slave (
    input  req,
    input  idx,
    output data,
    output valid,
    output rd_err
  );
endinterface

// File: rtl/contadores_param.sv
// -----------------------------------------------------------------------------
// contadores_param
// Counts the words popped from each of NUM_CH FIFOs while the main FSM is in
// ST_ACTIVE. Each counter saturates at 2**CNT_BITS-1 and sets a sticky ovf
// flag when that happens. While the main FSM is in ST_IDLE, the host can read
// any counter through the req/idx port. The response arrives one cycle later
// and is registered.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   estado_FSM current state of the main FSM
//   fifo_pop   per-channel pop strobe, one word per asserted cycle
//   ovf        sticky per-channel saturation flag
//   rd_if      readout port (req/idx in, data/valid/rd_err out)
//
// Build option
//   CONTADORES_CLR_ON_READ_EN : when defined, an accepted read clears the
//   counter and ovf flag of the channel it reads. When undefined, reads leave
//   the counters unchanged.
// -----------------------------------------------------------------------------
module contadores_param #(
  parameter int         NUM_CH    = 4,
  parameter int         IDX_BITS  = 2,
  parameter int         CNT_BITS  = 5,
  parameter logic [3:0] ST_ACTIVE = 4'b1000,
  parameter logic [3:0] ST_IDLE   = 4'b0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        estado_FSM,
  input  logic [NUM_CH-1:0] fifo_pop,
  output logic [NUM_CH-1:0] ovf,
  contadores_param_if.slave rd_if
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  rd_state_t           r_state;
  rd_state_t           w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt     [NUM_CH];
  logic [CNT_BITS-1:0] w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]   r_ovf;
  logic [NUM_CH-1:0]   w_ovf_nxt;
  logic [CNT_BITS-1:0] r_data;
  logic [CNT_BITS-1:0] w_data_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_rd_err;
  logic                w_rd_err_nxt;

  logic                w_counting;
  logic                w_idx_ok;
  logic                w_accept;
  logic [NUM_CH-1:0]   w_sel_hot;
  logic [CNT_BITS-1:0] w_sel_cnt;
  logic [NUM_CH-1:0]   w_clr;

  assign w_counting = (estado_FSM == ST_ACTIVE);
  // Compare at 32 bits, because NUM_CH may equal 2**IDX_BITS.
  assign w_idx_ok   = (32'(rd_if.idx) < 32'(NUM_CH));
  assign w_accept   = rd_if.req && (estado_FSM == ST_IDLE) && w_idx_ok;

  // Decode idx to a one-hot channel select and mux out the current count.
  // Out-of-range idx selects nothing, so the mux never indexes past the array.
  always_comb begin
    w_sel_hot = {NUM_CH{1'b0}};
    w_sel_cnt = {CNT_BITS{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(rd_if.idx) == 32'(i)) begin
        w_sel_hot[i] = 1'b1;
        w_sel_cnt    = r_cnt[i];
      end else begin
        w_sel_hot[i] = 1'b0;
      end
    end
  end

`ifdef CONTADORES_CLR_ON_READ_EN
  assign w_clr = w_accept ? w_sel_hot : {NUM_CH{1'b0}};
`else
  assign w_clr = {NUM_CH{1'b0}};
`endif

  // Next count and ovf for each channel: clear-on-read takes priority, then
  // saturating increment, otherwise hold.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_ovf_nxt[i] = r_ovf[i];
      if (w_clr[i]) begin
        // A pop in the same cycle as the read is counted after the clear.
        w_cnt_nxt[i] = (w_counting && fifo_pop[i]) ? CNT_ONE : {CNT_BITS{1'b0}};
        w_ovf_nxt[i] = 1'b0;
      end else if (w_counting && fifo_pop[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= {CNT_BITS{1'b0}};
      end
      r_ovf <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_ovf <= w_ovf_nxt;
    end
  end

  // Readout FSM next state and response. A request in either state produces
  // a response on the next cycle. Without a request, the FSM drops back to
  // RD_IDLE with all outputs at zero. The data is the count before this edge
  // updates it, so a same-cycle pop is not yet included.
  always_comb begin
    w_state_nxt  = RD_IDLE;
    w_data_nxt   = {CNT_BITS{1'b0}};
    w_valid_nxt  = 1'b0;
    w_rd_err_nxt = 1'b0;
    case (r_state)
      RD_IDLE, RD_RESP: begin
        if (rd_if.req) begin
          w_state_nxt = RD_RESP;
          if (w_accept) begin
            w_data_nxt  = w_sel_cnt;
            w_valid_nxt = 1'b1;
          end else begin
            w_rd_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = RD_IDLE;
        end
      end
      default: begin
        w_state_nxt = RD_IDLE;
      end
    endcase
  end

  // Readout state and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RD_IDLE;
      r_data   <= {CNT_BITS{1'b0}};
      r_valid  <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_rd_err <= w_rd_err_nxt;
    end
  end

  assign rd_if.data   = r_data;
  assign rd_if.valid  = r_valid;
  assign rd_if.rd_err = r_rd_err;
  assign ovf          = r_ovf;

endmodule

// File: tb/tb_contadores_param.sv
module tb_contadores_param;

  localparam logic [3:0] ST_ACTIVE = 4'b1000;
  localparam logic [3:0] ST_IDLE   = 4'b0001;

  logic       clk;
  logic       rst;
  logic [3:0] estado;
  logic [3:0] pop;
  logic [3:0] ovf;
  logic [2:0] pop3;
  logic [2:0] ovf3;

  int n_tests;
  int n_fail;

  contadores_param_if #(.IDX_BITS(2), .CNT_BITS(5)) bus  ();
  contadores_param_if #(.IDX_BITS(2), .CNT_BITS(5)) bus3 ();

  contadores_param #(
    .NUM_CH(4), .IDX_BITS(2), .CNT_BITS(5),
    .ST_ACTIVE(ST_ACTIVE), .ST_IDLE(ST_IDLE)
  ) dut (
    .clk(clk), .rst(rst), .estado_FSM(estado),
    .fifo_pop(pop), .ovf(ovf), .rd_if(bus)
  );

  contadores_param #(
    .NUM_CH(3), .IDX_BITS(2), .CNT_BITS(5),
    .ST_ACTIVE(ST_ACTIVE), .ST_IDLE(ST_IDLE)
  ) dut3 (
    .clk(clk), .rst(rst), .estado_FSM(estado),
    .fifo_pop(pop3), .ovf(ovf3), .rd_if(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.data !== 5'd0) begin n_fail++; $display("FAIL reset_data got=%0d exp=0", bus.data); end
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", bus.valid); end
    n_tests++; if (bus.rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err got=%0b exp=0", bus.rd_err); end
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0000", ovf); end
    rst = 1'b1;
    tick();
  endtask

  // ch0 gets 3 pops and ch2 gets 7, then all four channels are read back-to-back.
  task automatic test_count_read();
    estado = ST_ACTIVE;
    for (int i = 0; i < 7; i++) begin
      pop = {1'b0, 1'b1, 1'b0, (i < 3)};
      tick();
    end
    pop = 4'b0000;
    estado = ST_IDLE;
    bus.req = 1'b1; bus.idx = 2'd0;
    tick();
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd3) begin n_fail++; $display("FAIL read_ch0 got v=%0b d=%0d exp v=1 d=3", bus.valid, bus.data); end
    bus.idx = 2'd2;
    tick();
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd7) begin n_fail++; $display("FAIL read_ch2 got v=%0b d=%0d exp v=1 d=7", bus.valid, bus.data); end
    bus.idx = 2'd1;
    tick();
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd0) begin n_fail++; $display("FAIL read_ch1 got v=%0b d=%0d exp v=1 d=0", bus.valid, bus.data); end
    bus.idx = 2'd3;
    tick();
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd0 || bus.rd_err !== 1'b0) begin n_fail++; $display("FAIL read_ch3 got v=%0b d=%0d e=%0b exp v=1 d=0 e=0", bus.valid, bus.data, bus.rd_err); end
    bus.req = 1'b0;
    tick();
    n_tests++; if (bus.valid !== 1'b0 || bus.data !== 5'd0) begin n_fail++; $display("FAIL resp_end got v=%0b d=%0d exp v=0 d=0", bus.valid, bus.data); end
  endtask

  // 40 pops on ch1 drive it to saturation.
  task automatic test_saturation();
    estado = ST_ACTIVE;
    pop = 4'b0010;
    for (int i = 0; i < 40; i++) tick();
    pop = 4'b0000;
    n_tests++; if (ovf !== 4'b0010) begin n_fail++; $display("FAIL sat_ovf got=%b exp=0010", ovf); end
    estado = ST_IDLE;
    bus.req = 1'b1; bus.idx = 2'd1;
    tick();
    bus.req = 1'b0;
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd31) begin n_fail++; $display("FAIL sat_read got v=%0b d=%0d exp v=1 d=31", bus.valid, bus.data); end
`ifdef CONTADORES_CLR_ON_READ_EN
    n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL sat_ovf_after_read got=%b exp=0000", ovf); end
`else
    n_tests++; if (ovf !== 4'b0010) begin n_fail++; $display("FAIL sat_ovf_after_read got=%b exp=0010", ovf); end
`endif
    tick();
  endtask

  // A request made while the main FSM is active is rejected and changes nothing.
  task automatic test_reject_active();
    logic [4:0] exp_ch1;
`ifdef CONTADORES_CLR_ON_READ_EN
    exp_ch1 = 5'd0;
`else
    exp_ch1 = 5'd31;
`endif
    estado = ST_ACTIVE;
    bus.req = 1'b1; bus.idx = 2'd1;
    tick();
    bus.req = 1'b0;
    n_tests++; if (bus.valid !== 1'b0 || bus.rd_err !== 1'b1 || bus.data !== 5'd0) begin n_fail++; $display("FAIL reject_active got v=%0b e=%0b d=%0d exp v=0 e=1 d=0", bus.valid, bus.rd_err, bus.data); end
    tick();
    n_tests++; if (bus.rd_err !== 1'b0) begin n_fail++; $display("FAIL reject_pulse_len got e=%0b exp e=0", bus.rd_err); end
    estado = ST_IDLE;
    bus.req = 1'b1; bus.idx = 2'd1;
    tick();
    // While this response is held, the main FSM leaves ST_IDLE.
    estado = ST_ACTIVE;
    bus.req = 1'b0;
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== exp_ch1) begin n_fail++; $display("FAIL reject_no_change got v=%0b d=%0d exp v=1 d=%0d", bus.valid, bus.data, exp_ch1); end
    tick();
    estado = ST_IDLE;
    tick();
  endtask

  // On the 3-channel build, idx=3 is out of range and is rejected.
  task automatic test_idx_range();
    estado = ST_IDLE;
    bus3.req = 1'b1; bus3.idx = 2'd3;
    tick();
    n_tests++; if (bus3.rd_err !== 1'b1 || bus3.valid !== 1'b0 || bus3.data !== 5'd0) begin n_fail++; $display("FAIL idx_oob got e=%0b v=%0b d=%0d exp e=1 v=0 d=0", bus3.rd_err, bus3.valid, bus3.data); end
    bus3.idx = 2'd2;
    tick();
    bus3.req = 1'b0;
    n_tests++; if (bus3.rd_err !== 1'b0 || bus3.valid !== 1'b1 || bus3.data !== 5'd0) begin n_fail++; $display("FAIL idx_last got e=%0b v=%0b d=%0d exp e=0 v=1 d=0", bus3.rd_err, bus3.valid, bus3.data); end
    tick();
  endtask

  // ch3 counts 5 pops and is then read twice in a row.
  task automatic test_clr_on_read();
    logic [4:0] exp_second;
`ifdef CONTADORES_CLR_ON_READ_EN
    exp_second = 5'd0;
`else
    exp_second = 5'd5;
`endif
    estado = ST_ACTIVE;
    pop = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    pop = 4'b0000;
    estado = ST_IDLE;
    bus.req = 1'b1; bus.idx = 2'd3;
    tick();
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd5) begin n_fail++; $display("FAIL cor_first got v=%0b d=%0d exp v=1 d=5", bus.valid, bus.data); end
    tick();
    bus.req = 1'b0;
    n_tests++; if (bus.valid !== 1'b1 || bus.data !== exp_second) begin n_fail++; $display("FAIL cor_second got v=%0b d=%0d exp v=1 d=%0d", bus.valid, bus.data, exp_second); end
    tick();
  endtask

  // Reset is asserted between clock edges while a response is being held.
  task automatic test_reset_mid();
    estado = ST_ACTIVE;
    pop = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    pop = 4'b0000;
    estado = ST_IDLE;
    bus.req = 1'b1; bus.idx = 2'd0;
    tick();
    n_tests++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got v=%0b exp v=1", bus.valid); end
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (bus.valid !== 1'b0 || bus.data !== 5'd0 || bus.rd_err !== 1'b0 || ovf !== 4'b0000) begin n_fail++; $display("FAIL mid_async got v=%0b d=%0d e=%0b ovf=%b exp all 0", bus.valid, bus.data, bus.rd_err, ovf); end
    bus.req = 1'b0;
    tick();
    rst = 1'b1;
    bus.req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.idx = i[1:0];
      tick();
      n_tests++; if (bus.valid !== 1'b1 || bus.data !== 5'd0) begin n_fail++; $display("FAIL mid_readback ch%0d got v=%0b d=%0d exp v=1 d=0", i, bus.valid, bus.data); end
    end
    bus.req = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    estado = 4'b0000;
    pop = 4'b0000;
    pop3 = 3'b000;
    bus.req = 1'b0;  bus.idx = 2'd0;
    bus3.req = 1'b0; bus3.idx = 2'd0;
    test_reset();
    test_count_read();
    test_saturation();
    test_reject_active();
    test_idx_range();
    test_clr_on_read();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contadores_param.md
Name: contadores_param

Overview:
- Parametrised successor to the fixed 4-channel, 5-bit word counters.
- Counts words popped from each of NUM_CH FIFOs while the main FSM is in its active state.
- Serves a req/idx readout port with a registered data/valid response while the FSM is idle.
- Adds saturation, per-channel sticky overflow flags and readout error reporting; sits beside the FIFO bank and reports to the probador/host side.

Parameters:
- NUM_CH, 4, number of FIFO channels counted (1..2**IDX_BITS).
- IDX_BITS, 2, width of the idx select bus.
- CNT_BITS, 5, width of each counter and of data.
- ST_ACTIVE, 4'b1000, estado_FSM encoding in which counting is enabled.
- ST_IDLE, 4'b0001, estado_FSM encoding in which readout is permitted.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- estado_FSM  input  4  current state of the main FSM.
- fifo_pop  input  NUM_CH  per-channel pop strobe, one word per asserted cycle.
- req  input  1  readout request, sampled each cycle.
- idx  input  IDX_BITS  channel selected for readout, sampled with req.
- data  output  CNT_BITS  count of the selected channel, registered.
- valid  output  1  one-cycle qualifier for data.
- ovf  output  NUM_CH  sticky per-channel saturation flag.
- rd_err  output  1  one-cycle pulse for a rejected request.

Behaviour:
- Reset (rst=0, async): all counters=0, data=0, valid=0, ovf=0, rd_err=0, readout FSM=RD_IDLE. Release is synchronous to the next clk edge.
- Counting: on each clk edge where estado_FSM==ST_ACTIVE and fifo_pop[i]=1, cnt[i] increments by 1.
  - Channels are independent; any number may increment in the same cycle.
  - In all other estado_FSM values, pops are ignored and counters hold.
- Saturation: when cnt[i]==2**CNT_BITS-1 and a counted pop occurs, cnt[i] holds at max and ovf[i] sets.
  - ovf[i] clears only on reset (or on read, with the optional feature).
- Readout FSM has two states, RD_IDLE and RD_RESP.
  - RD_IDLE: if req=1 at an edge, the FSM enters RD_RESP and drives a response on the following cycle (latency 1).
    - Accepted request (estado_FSM==ST_IDLE and idx<NUM_CH): data=cnt[idx] as sampled at the req edge, valid=1, rd_err=0.
    - Rejected request (estado_FSM!=ST_IDLE, or idx>=NUM_CH): data=0, valid=0, rd_err=1.
  - RD_RESP: outputs last exactly one cycle.
    - req=1 at this edge: a new request is processed as above and the FSM stays in RD_RESP.
    - req=0: the FSM returns to RD_IDLE; data returns to 0, valid and rd_err return to 0.
  - Throughput is one request per cycle. Back-to-back reqs give back-to-back responses.
- Same-cycle pop and read on one channel: data returns the pre-increment value; the counter still increments.
  - This only happens if ST_ACTIVE==ST_IDLE; with the defaults it is unreachable, but the rule is binding.
- estado_FSM leaving ST_IDLE while a response is in flight: the response already registered completes normally.
- Reset mid-operation: all state clears immediately and any pending response is dropped (valid forced 0 asynchronously).
- No arithmetic wraps: counters never roll from max to 0.

Optional Feature:
- Macro CONTADORES_CLR_ON_READ_EN.
- When defined: an accepted read returns cnt[idx] and clears cnt[idx] and ovf[idx] on the same edge.
  - A same-cycle counted pop on that channel leaves cnt[idx]=1.
  - Rejected reads never clear anything.
- When undefined: reads are non-destructive; counters and ovf change only via counting and reset.

Test Plan:
- Reset then ST_ACTIVE, 3 pops ch0 and 7 pops ch2, switch to ST_IDLE, req idx=0 then idx=2 back-to-back -> valid=1 on two consecutive cycles with data=3, then data=7; ch1/ch3 read 0.
- 40 pops on ch1 in ST_ACTIVE (CNT_BITS=5) -> read data=31, ovf=4'b0010; other ovf bits 0.
- req with estado_FSM=ST_ACTIVE, idx=1 -> valid=0, rd_err=1 for one cycle, data=0; counters unchanged.
- NUM_CH=3, IDX_BITS=2 build, req idx=3 in ST_IDLE -> rd_err=1, valid=0.
- Drive rst=0 mid-count (asynchronously, between edges) with valid=1 outstanding -> all outputs 0 immediately; subsequent read of every channel returns 0.
- With CONTADORES_CLR_ON_READ_EN: count 5 on ch3, read idx=3 twice -> data=5 then data=0; without the macro -> 5 then 5.
